// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word width, MDU opcode encoding, iteration count
// and a two's-complement magnitude helper used by the MDU.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdop_t;

    localparam int MDU_ITER = 32;

    function automatic word_t abs_w(input word_t v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/mdu.sv
// mdu: iterative radix-2 multiply / restoring divide with HI/LO registers.
// Ports: CLK, RST (sync, active-high); start/mdop/portA/portB request;
// wr_hi/wr_lo MTHI/MTLO writes; busy/done/divzero status; hi/lo results.
// Optional abort input when MDU_ABORT_EN is defined.
module mdu
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  start,
    input  mdop_t mdop,
    input  word_t portA,
    input  word_t portB,
    input  logic  wr_hi,
    input  logic  wr_lo,
`ifdef MDU_ABORT_EN
    input  logic  abort,
`endif
    output logic  busy,
    output logic  done,
    output logic  divzero,
    output word_t hi,
    output word_t lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [4:0] CNT_INIT = 5'(MDU_ITER - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    mdop_t       op_q, op_d;
    word_t       opnd_q, opnd_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic        zero_q, zero_d;
    logic [63:0] acc_q, acc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;
    word_t       hi_q, hi_d;
    word_t       lo_q, lo_d;

    // Start-side operand preparation
    logic  st_signed, st_div, st_zero;
    word_t a_mag, b_mag;

    // Datapath step results
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic        div_ge;
    word_t       div_diff;
    logic [63:0] div_next;

    // Sign correction
    logic        op_signed, op_div, neg_res;
    logic [63:0] prod;
    word_t       quo, rem;

    always_comb begin
        st_signed = ~mdop[0];
        st_div    = mdop[1];
        st_zero   = st_div && (portB == '0);
        a_mag     = st_signed ? abs_w(portA) : portA;
        b_mag     = st_signed ? abs_w(portB) : portB;

        // acc = {partial product, remaining multiplier bits}
        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[31:1]}
                            : {1'b0, acc_q[63:1]};

        // acc = {partial remainder, remaining dividend / quotient bits}
        rem_sh   = {acc_q[63:32], acc_q[31]};
        div_ge   = rem_sh >= {1'b0, opnd_q};
        div_diff = rem_sh[31:0] - opnd_q;
        div_next = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                          : {rem_sh[31:0], acc_q[30:0], 1'b0};

        op_signed = ~op_q[0];
        op_div    = op_q[1];
        neg_res   = op_signed && (sa_q ^ sb_q);
        prod      = neg_res ? -acc_q : acc_q;
        quo       = neg_res ? -acc_q[31:0] : acc_q[31:0];
        rem       = (op_signed && sa_q) ? -acc_q[63:32]
                                        : acc_q[63:32];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        zero_d  = zero_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = mdop;
                    sa_d   = st_signed && portA[31];
                    sb_d   = st_signed && portB[31];
                    zero_d = st_zero;
                    busy_d = 1'b1;
                    cnt_d  = CNT_INIT;
                    opnd_d = st_div ? b_mag : a_mag;
                    if (st_zero) begin
                        // Keep raw dividend for the HI result
                        state_d = S_FIX;
                        acc_d   = {portA, 32'h0};
                    end else begin
                        state_d = S_CALC;
                        acc_d   = {32'h0, st_div ? a_mag : b_mag};
                    end
                end else begin
                    if (wr_hi) hi_d = portA;
                    if (wr_lo) lo_d = portA;
                end
            end
            S_CALC: begin
                acc_d = op_div ? div_next : mul_next;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_FIX: begin
                if (!op_div) begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end else if (zero_q) begin
                    hi_d = acc_q[63:32];
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                dz_d    = op_div && zero_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

`ifdef MDU_ABORT_EN
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            dz_d    = dz_q;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_MULT;
            opnd_q  <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            zero_q  <= 1'b0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            zero_q  <= zero_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign divzero = dz_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: vector table plus handshake / reset
// sequences. Abort sequence is built when MDU_ABORT_EN is defined.
module tb_mdu;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  RST = 1'b1;
    logic  start = 1'b0;
    mdop_t mdop = MDU_MULT;
    word_t portA = '0;
    word_t portB = '0;
    logic  wr_hi = 1'b0;
    logic  wr_lo = 1'b0;
    logic  abort = 1'b0;
    logic  busy, done, divzero;
    word_t hi, lo;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    mdu dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .mdop    (mdop),
        .portA   (portA),
        .portB   (portB),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
`ifdef MDU_ABORT_EN
        .abort   (abort),
`endif
        .busy    (busy),
        .done    (done),
        .divzero (divzero),
        .hi      (hi),
        .lo      (lo)
    );

    typedef struct {
        mdop_t op;
        word_t a;
        word_t b;
        word_t e_hi;
        word_t e_lo;
        logic  e_dz;
        int    e_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Issue one op; return edges to done, busy cycles, results.
    task automatic run_op(input mdop_t op, input word_t a, input word_t b,
                          input logic wr, output int lat, output int bc,
                          output word_t rhi, output word_t rlo,
                          output logic rdz, output logic dn_next);
        @(negedge CLK);
        mdop = op; portA = a; portB = b;
        start = 1'b1; wr_hi = wr; wr_lo = wr;
        @(posedge CLK); #1;
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        portA = $urandom; portB = $urandom;
        lat = 0; bc = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(posedge CLK); #1;
            lat++;
        end
        rhi = hi; rlo = lo; rdz = divzero;
        @(posedge CLK); #1;
        dn_next = done;
    endtask

    initial begin
        int lat, bc;
        word_t rhi, rlo;
        logic rdz, dnn;
        string n;

        vecs[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vecs[1]  = '{MDU_MULT, 32'hFFFFFFFD, 32'd7,
                     32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
        vecs[2]  = '{MDU_DIV, 32'hFFFFFFF9, 32'd2,
                     32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3]  = '{MDU_DIVU, 32'd100, 32'd7,
                     32'd2, 32'd14, 1'b0, 33};
        vecs[4]  = '{MDU_DIV, 32'h80000000, 32'hFFFFFFFF,
                     32'h0, 32'h80000000, 1'b0, 33};
        vecs[5]  = '{MDU_DIVU, 32'd5, 32'd0,
                     32'd5, 32'hFFFFFFFF, 1'b1, 1};
        vecs[6]  = '{MDU_MULT, 32'h80000000, 32'h80000000,
                     32'h40000000, 32'h0, 1'b0, 33};
        vecs[7]  = '{MDU_DIV, 32'd7, 32'hFFFFFFFE,
                     32'd1, 32'hFFFFFFFD, 1'b0, 33};
        vecs[8]  = '{MDU_MULTU, 32'h00010000, 32'h00010000,
                     32'd1, 32'h0, 1'b0, 33};
        vecs[9]  = '{MDU_DIV, 32'hFFFFFFFB, 32'd0,
                     32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1};
        vecs[10] = '{MDU_DIVU, 32'hFFFFFFFF, 32'd1,
                     32'h0, 32'hFFFFFFFF, 1'b0, 33};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dz", 32'(divzero), 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);

        // MTHI/MTLO together, then MTHI alone
        @(negedge CLK);
        portA = 32'hA5A5_1234; wr_hi = 1'b1; wr_lo = 1'b1;
        @(negedge CLK);
        portA = 32'h0BAD_F00D; wr_lo = 1'b0;
        @(negedge CLK);
        wr_hi = 1'b0;
        chk("wr_hi", hi, 32'h0BAD_F00D);
        chk("wr_lo", lo, 32'hA5A5_1234);

        // Vector table
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0,
                   lat, bc, rhi, rlo, rdz, dnn);
            n = $sformatf("v%0d", i);
            chk({n, "_lat"}, 32'(lat), 32'(vecs[i].e_lat));
            chk({n, "_busy"}, 32'(bc), 32'(vecs[i].e_lat));
            chk({n, "_hi"}, rhi, vecs[i].e_hi);
            chk({n, "_lo"}, rlo, vecs[i].e_lo);
            chk({n, "_dz"}, 32'(rdz), 32'(vecs[i].e_dz));
            chk({n, "_pulse"}, 32'(dnn), 0);
        end

        // start wins over wr_hi/wr_lo in the same IDLE cycle
        run_op(MDU_MULTU, 32'd3, 32'd5, 1'b1,
               lat, bc, rhi, rlo, rdz, dnn);
        chk("st_wr_lo", rlo, 32'd15);
        chk("st_wr_hi", rhi, 32'd0);

        // start and wr_hi while busy are ignored
        @(negedge CLK);
        mdop = MDU_DIVU; portA = 32'd100; portB = 32'd7; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        mdop = MDU_MULTU; portA = 32'h0000DEAD; portB = 32'd3;
        start = 1'b1; wr_hi = 1'b1; wr_lo = 1'b1;
        @(negedge CLK);
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        chk("busy_hi_hold", hi, 32'd0);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        chk("busy_lat", 32'(lat), 29);
        chk("busy_q", lo, 32'd14);
        chk("busy_r", hi, 32'd2);
        @(negedge CLK);
        chk("busy_no_queue", 32'(busy), 0);

`ifdef MDU_ABORT_EN
        // abort at iteration 5 keeps prior HI/LO, no done
        @(negedge CLK);
        mdop = MDU_MULTU; portA = 32'hFFFFFFFF; portB = 32'hFFFFFFFF;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        abort = 1'b1;
        @(posedge CLK); #1;
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_done", 32'(done), 0);
        rdz = 1'b0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (done) rdz = 1'b1;
        end
        chk("ab_nodone", 32'(rdz), 0);
        chk("ab_hi", hi, 32'd2);
        chk("ab_lo", lo, 32'd14);
`endif

        // Reset at iteration 10 clears everything
        run_op(MDU_DIVU, 32'd9, 32'd0, 1'b0,
               lat, bc, rhi, rlo, rdz, dnn);
        @(negedge CLK);
        mdop = MDU_MULTU; portA = 32'hFFFFFFFF; portB = 32'hFFFFFFFF;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_done", 32'(done), 0);
        chk("mrst_dz", 32'(divzero), 0);
        chk("mrst_hi", hi, 0);
        chk("mrst_lo", lo, 0);
        repeat (30) @(posedge CLK);
        #1;
        chk("mrst_idle_lo", lo, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
